// File: rtl/snake_body_walker.sv
// Walks the snake body direction stream from the head toward the tail, rebuilding
// each segment coordinate and reporting the first segment that lands on the query cell.
module snake_body_walker #(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 220,
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 4,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_BITS-1:0]   head_x,
  input  logic [Y_BITS-1:0]   head_y,
  input  logic [LEN_BITS-1:0] length,
  input  logic [X_BITS-1:0]   query_x,
  input  logic [Y_BITS-1:0]   query_y,
  input  logic                dir_valid,
  input  logic [WIDTH-1:0]    dir,
  output logic                dir_ready,
  output logic                busy,
  output logic                seg_valid,
  output logic [X_BITS-1:0]   seg_x,
  output logic [Y_BITS-1:0]   seg_y,
  output logic                done,
  output logic                hit,
  output logic [LEN_BITS-1:0] hit_index
);

  localparam logic [WIDTH-1:0]    DIR_UP    = WIDTH'(0);
  localparam logic [WIDTH-1:0]    DIR_RIGHT = WIDTH'(1);
  localparam logic [WIDTH-1:0]    DIR_DOWN  = WIDTH'(2);
  localparam logic [LEN_BITS-1:0] MAX_LEN   = LEN_BITS'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    WALK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [X_BITS-1:0]   seg_x_reg, step_x;
  logic [Y_BITS-1:0]   seg_y_reg, step_y;
  logic [X_BITS-1:0]   query_x_reg;
  logic [Y_BITS-1:0]   query_y_reg;
  logic [LEN_BITS-1:0] remain_reg, index_reg, hit_index_reg, len_clamped;
  logic                seg_valid_reg, hit_reg;
  logic                start_accept, consume, last_code;

  assign start_accept = (state_reg == IDLE) && start;
  assign consume      = (state_reg == WALK) && dir_valid;
  assign last_code    = (remain_reg == LEN_BITS'(1));
  assign len_clamped  = (length > MAX_LEN) ? MAX_LEN : length;

  // Each code records how the snake entered a segment, so walking tailward steps the opposite way.
  always_comb begin
    step_x = seg_x_reg;
    step_y = seg_y_reg;
    case (dir)
      DIR_UP:    step_y = seg_y_reg + Y_BITS'(1);
      DIR_RIGHT: step_x = seg_x_reg - X_BITS'(1);
      DIR_DOWN:  step_y = seg_y_reg - Y_BITS'(1);
      default:   step_x = seg_x_reg + X_BITS'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    dir_ready  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = HEAD;
      end
      HEAD: begin
        busy       = 1'b1;
        state_next = (remain_reg == '0) ? DONE : WALK;
      end
      WALK: begin
        busy      = 1'b1;
        dir_ready = 1'b1;
        if (dir_valid && last_code) state_next = DONE;
      end
      default: begin
        done       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Hit is evaluated on the value being loaded into seg, so it is current in the same cycle seg_valid is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_x_reg     <= '0;
      seg_y_reg     <= '0;
      seg_valid_reg <= 1'b0;
      query_x_reg   <= '0;
      query_y_reg   <= '0;
      remain_reg    <= '0;
      index_reg     <= '0;
      hit_reg       <= 1'b0;
      hit_index_reg <= '0;
    end else if (start_accept) begin
      seg_x_reg     <= head_x;
      seg_y_reg     <= head_y;
      seg_valid_reg <= 1'b1;
      query_x_reg   <= query_x;
      query_y_reg   <= query_y;
      remain_reg    <= len_clamped;
      index_reg     <= '0;
      hit_reg       <= (head_x == query_x) && (head_y == query_y);
      hit_index_reg <= '0;
    end else if (consume) begin
      seg_x_reg     <= step_x;
      seg_y_reg     <= step_y;
      seg_valid_reg <= 1'b1;
      remain_reg    <= remain_reg - LEN_BITS'(1);
      index_reg     <= index_reg + LEN_BITS'(1);
      if (!hit_reg && (step_x == query_x_reg) && (step_y == query_y_reg)) begin
        hit_reg       <= 1'b1;
        hit_index_reg <= index_reg + LEN_BITS'(1);
      end
    end else begin
      seg_valid_reg <= 1'b0;
    end
  end

  assign seg_x     = seg_x_reg;
  assign seg_y     = seg_y_reg;
  assign seg_valid = seg_valid_reg;
  assign hit       = hit_reg;
  assign hit_index = hit_index_reg;

endmodule

// File: tb/tb_snake_body_walker.sv
// Randomized scoreboard bench for snake_body_walker: the body is rebuilt from the
// direction codes with plain grid arithmetic and compared segment by segment.
module tb_snake_body_walker;

  logic       clk, rst_n, start;
  logic [4:0] head_x, query_x, seg_x;
  logic [3:0] head_y, query_y, seg_y;
  logic [7:0] length, hit_index;
  logic       dir_valid, dir_ready, busy, seg_valid, done, hit;
  logic [1:0] dir;

  snake_body_walker dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .head_x(head_x), .head_y(head_y), .length(length),
    .query_x(query_x), .query_y(query_y),
    .dir_valid(dir_valid), .dir(dir), .dir_ready(dir_ready),
    .busy(busy), .seg_valid(seg_valid), .seg_x(seg_x), .seg_y(seg_y),
    .done(done), .hit(hit), .hit_index(hit_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int x;
    int y;
    bit hit;
    int idx;
    int lat;
    int nready;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, start_cyc = 0, ready_cnt = 0;
  bit   mon_off = 1'b1;
  int   code_arr [0:255];
  int   stall_arr[0:255];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Tailward step from a segment: opposite of the direction the snake moved into it.
  function automatic int step_pos(input int pos, input int code);
    int x, y;
    x = pos / 16;
    y = pos % 16;
    case (code)
      0: y = (y + 1) % 16;
      1: x = (x + 31) % 32;
      2: y = (y + 15) % 16;
      default: x = (x + 1) % 32;
    endcase
    return x * 16 + y;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a segment or finishes a walk.
  always @(negedge clk) begin
    if (rst_n && !mon_off) begin
      if (dir_ready) ready_cnt++;
      if (seg_valid) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          chk("unexpected_seg", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("seg_x", int'(seg_x), e.x);
          chk("seg_y", int'(seg_y), e.y);
          $display("seg (%0d,%0d) expected (%0d,%0d)", seg_x, seg_y, e.x, e.y);
        end
      end
      if (done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hit", int'(hit), int'(e.hit));
          chk("hit_index", int'(hit_index), e.idx);
          chk("latency", cyc - start_cyc, e.lat);
          chk("codes_consumed", ready_cnt, e.nready);
          $display("done hit=%0d idx=%0d lat=%0d (exp %0d/%0d/%0d)",
                   hit, hit_index, cyc - start_cyc, e.hit, e.idx, e.lat);
        end
        ready_cnt = 0;
      end
    end
  end

  task automatic run_walk(input int hx, input int hy, input int len,
                          input int qx, input int qy, input bit inject_mid);
    int   L, pos, first, total_stall, ptr, stall_left, guard;
    bit   injected;
    exp_t e;
    L = (len > 220) ? 220 : len;
    chk("sb_empty", sb.size(), 0);
    sb.delete();
    pos = hx * 16 + hy;
    first = (hx == qx && hy == qy) ? 0 : -1;
    total_stall = 0;
    e = '{is_done: 1'b0, x: hx, y: hy, hit: 1'b0, idx: 0, lat: 0, nready: 0};
    sb.push_back(e);
    for (int i = 0; i < L; i++) begin
      pos = step_pos(pos, code_arr[i]);
      if (first < 0 && pos == qx * 16 + qy) first = i + 1;
      total_stall += stall_arr[i];
      e = '{is_done: 1'b0, x: pos / 16, y: pos % 16, hit: 1'b0, idx: 0, lat: 0, nready: 0};
      sb.push_back(e);
    end
    e = '{is_done: 1'b1, x: 0, y: 0, hit: (first >= 0), idx: (first < 0) ? 0 : first,
          lat: L + 2 + total_stall, nready: L + total_stall};
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1;
    head_x = 5'(hx); head_y = 4'(hy); length = 8'(len);
    query_x = 5'(qx); query_y = 4'(qy);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    head_x = 5'($urandom); head_y = 4'($urandom); query_x = 5'($urandom); query_y = 4'($urandom);
    length = 8'($urandom);
    ptr = 0;
    stall_left = (L > 0) ? stall_arr[0] : 0;
    guard = 0;
    injected = 1'b0;
    forever begin
      if (done) begin
        start = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored", int'(busy), 0);
        start = 1'b0;
        break;
      end
      if (dir_ready && ptr < L) begin
        if (stall_left > 0) begin
          dir_valid = 1'b0;
          dir = 2'($urandom);
          stall_left--;
        end else begin
          dir_valid = 1'b1;
          dir = 2'(code_arr[ptr]);
          ptr++;
          stall_left = (ptr < L) ? stall_arr[ptr] : 0;
        end
      end else begin
        dir_valid = 1'($urandom);
        dir = 2'($urandom);
      end
      if (inject_mid && ptr == 1 && !injected) begin
        start = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      guard++;
      if (guard > 3000) begin
        chk("walk_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      code_arr[i] = int'($urandom % 4);
      stall_arr[i] = 0;
    end
  endtask

  initial begin
    int hx, hy, len, k, pos, qx, qy;
    rst_n = 1'b0; start = 1'b0; dir_valid = 1'b0; dir = 2'd0;
    head_x = '0; head_y = '0; length = '0; query_x = '0; query_y = '0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_dir_ready", int'(dir_ready), 0);
    chk("rst_seg_valid", int'(seg_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_seg_xy", int'(seg_x) + int'(seg_y), 0);
    chk("rst_hit_index", int'(hit_index), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_off = 1'b0;

    clear_tables();
    code_arr[0] = 1; code_arr[1] = 1; code_arr[2] = 0;
    run_walk(10, 5, 3, 8, 5, 1'b0);
    clear_tables();
    code_arr[0] = 1; code_arr[1] = 0;
    run_walk(0, 0, 2, 31, 1, 1'b0);
    clear_tables();
    run_walk(7, 3, 0, 7, 3, 1'b0);
    clear_tables();
    code_arr[0] = 0; code_arr[1] = 0; code_arr[2] = 3; code_arr[3] = 3;
    stall_arr[2] = 3;
    run_walk(12, 8, 4, 1, 1, 1'b0);
    clear_tables();
    code_arr[0] = 0; code_arr[1] = 0; code_arr[2] = 2;
    run_walk(5, 5, 3, 5, 6, 1'b1);
    clear_tables();
    run_walk(20, 10, 250, int'($urandom % 32), int'($urandom % 16), 1'b1);

    for (int t = 0; t < 30; t++) begin
      clear_tables();
      hx = int'($urandom % 32);
      hy = int'($urandom % 16);
      len = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++)
        stall_arr[i] = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom % 2 == 0) begin
        k = int'($urandom_range(0, len));
        pos = hx * 16 + hy;
        for (int i = 0; i < k; i++) pos = step_pos(pos, code_arr[i]);
        qx = pos / 16;
        qy = pos % 16;
      end else begin
        qx = int'($urandom % 32);
        qy = int'($urandom % 16);
      end
      run_walk(hx, hy, len, qx, qy, 1'($urandom));
    end

    // Asynchronous reset in the middle of a walk, between clock edges.
    @(negedge clk);
    mon_off = 1'b1;
    start = 1'b1; head_x = 5'd4; head_y = 4'd4; length = 8'd10; query_x = 5'd4; query_y = 4'd4;
    @(negedge clk);
    start = 1'b0; dir_valid = 1'b1; dir = 2'd3;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_hit", int'(hit), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_dir_ready", int'(dir_ready), 0);
    chk("async_rst_seg_valid", int'(seg_valid), 0);
    chk("async_rst_hit", int'(hit), 0);
    chk("async_rst_hit_index", int'(hit_index), 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_dir_ready", int'(dir_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_dir_ready", int'(dir_ready), 0);
      chk("post_rst_seg_valid", int'(seg_valid), 0);
    end
    dir_valid = 1'b0;
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
